// File: rtl/branch_cmp_arbiter_pkg.sv
// Shared types and constants for the two-requester branch-compare arbiter.
// Holds the FSM state type, the branch funct3 encodings and the requester count.
package branch_cmp_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } arbState_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Only BLTU/BGEU compare as unsigned; every other encoding uses signed order.
  function automatic logic isUnsignedCmp(input logic [2:0] funct3);
    return (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/branch_cmp_arbiter_cmp.sv
// Purely combinational operand comparator: equality plus signed/unsigned less-than.
module branch_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             unsignedSel,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);

  always_comb begin
    if (unsignedSel) begin
      lt = (a < b);
    end else begin
      lt = ($signed(a) < $signed(b));
    end
  end

endmodule

// File: rtl/branch_cmp_arbiter.sv
// Round-robin arbiter feeding one shared branch comparator; one compare in flight,
// IDLE accepts, EVAL registers the result, RESP holds it until the consumer takes it.
module branch_cmp_arbiter
  import branch_cmp_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*3-1:0]     req_funct3_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_id_o,
  output logic                     rsp_taken_o,
  output logic                     rsp_err_o,
  output logic [CNT_W-1:0]         cmp_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arbState_e        state;
  arbState_e        stateNext;
  logic             lastGrant;
  logic             grantIdx;
  logic             accept;
  logic             rspFire;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       opF3;
  logic             opId;
  logic             resTaken;
  logic             resErr;
  logic [CNT_W-1:0] cmpCount;
  logic             cmpEq;
  logic             cmpLt;
  logic             evalTaken;
  logic             evalErr;

  // Contested grants go to whoever did not win last time.
  always_comb begin
    if (&req_valid_i) begin
      grantIdx = ~lastGrant;
    end else if (req_valid_i[1]) begin
      grantIdx = 1'b1;
    end else begin
      grantIdx = 1'b0;
    end
  end

  // Handshakes: a request moves on req_valid_i[i] & req_ready_o[i], a response
  // on rsp_valid_o & rsp_ready_i. Neither ready nor rsp_valid_o looks at rsp_ready_i.
  always_comb begin
    stateNext   = state;
    req_ready_o = '0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    rspFire     = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_o[grantIdx] = 1'b1;
          accept                = 1'b1;
          stateNext             = EVAL;
        end
      end
      EVAL: begin
        stateNext = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          rspFire   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  branch_cmp #(.WIDTH(WIDTH)) uCmp (
    .a          (opA),
    .b          (opB),
    .unsignedSel(isUnsignedCmp(opF3)),
    .eq         (cmpEq),
    .lt         (cmpLt)
  );

  always_comb begin
    evalTaken = 1'b0;
    evalErr   = 1'b0;
    case (opF3)
      F3_BEQ:  evalTaken = cmpEq;
      F3_BNE:  evalTaken = ~cmpEq;
      F3_BLT:  evalTaken = cmpLt;
      F3_BGE:  evalTaken = ~cmpLt;
      F3_BLTU: evalTaken = cmpLt;
      F3_BGEU: evalTaken = ~cmpLt;
      default: evalErr   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      opA       <= '0;
      opB       <= '0;
      opF3      <= '0;
      opId      <= 1'b0;
      resTaken  <= 1'b0;
      resErr    <= 1'b0;
      cmpCount  <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        opA       <= grantIdx ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
        opB       <= grantIdx ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
        opF3      <= grantIdx ? req_funct3_i[5:3] : req_funct3_i[2:0];
        opId      <= grantIdx;
        lastGrant <= grantIdx;
      end
      if (state == EVAL) begin
        resTaken <= evalTaken;
        resErr   <= evalErr;
      end
      if (rspFire && (cmpCount != CNT_MAX)) begin
        cmpCount <= cmpCount + 1'b1;
      end
    end
  end

  assign rsp_id_o    = opId;
  assign rsp_taken_o = resTaken;
  assign rsp_err_o   = resErr;
  assign cmp_count_o = cmpCount;

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
// Bench for branch_cmp_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_branch_cmp_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [2*WIDTH-1:0] req_a_i;
  logic [2*WIDTH-1:0] req_b_i;
  logic [5:0]         req_funct3_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic               rsp_id_o;
  logic               rsp_taken_o;
  logic               rsp_err_o;
  logic [CNT_W-1:0]   cmp_count_o;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_cmp_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_funct3_i(req_funct3_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_taken_o (rsp_taken_o),
    .rsp_err_o   (rsp_err_o),
    .cmp_count_o (cmp_count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Branch rule straight from the ISA definition: returns {taken, err}.
  function automatic logic [1:0] ref_resp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
    case (f3)
      3'b000:  return {a == b, 1'b0};
      3'b001:  return {a != b, 1'b0};
      3'b100:  return {$signed(a) < $signed(b), 1'b0};
      3'b101:  return {!($signed(a) < $signed(b)), 1'b0};
      3'b110:  return {a < b, 1'b0};
      3'b111:  return {!(a < b), 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  // ---------------- reference model + scoreboard ----------------
  // age: -1 no operation held, 0 accepted last edge, 1 response owed.
  int          age = -1;
  logic        last_g = 1'b1;
  int          m_count = 0;
  logic [2:0]  exp_q[$];   // {id, taken, err} of the operation in flight
  logic [2:0]  obs_q[$];   // {id, taken, err} seen on each DUT response handshake

  always @(negedge clk) begin
    logic [1:0]  exp_ready;
    logic        g;
    logic [1:0]  r;
    logic [2:0]  e;
    if (rst) begin
      age = -1;
      last_g = 1'b1;
      m_count = 0;
      exp_q.delete();
    end
    g = (&req_valid_i) ? ~last_g : (req_valid_i[1] ? 1'b1 : 1'b0);
    exp_ready = (age == -1 && (|req_valid_i)) ? (2'b01 << g) : 2'b00;
    chk("req_ready", req_ready_o, exp_ready);
    chk("rsp_valid", rsp_valid_o, (age == 1));
    chk("cmp_count", cmp_count_o, m_count);
    if (age == 1 && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("rsp_id", rsp_id_o, e[2]);
      chk("rsp_taken", rsp_taken_o, e[1]);
      chk("rsp_err", rsp_err_o, e[0]);
    end
    if (rsp_valid_o && rsp_ready_i) obs_q.push_back({rsp_id_o, rsp_taken_o, rsp_err_o});
    if (!rst) begin
      if (age == -1) begin
        if (|req_valid_i) begin
          r = g ? ref_resp(req_a_i[63:32], req_b_i[63:32], req_funct3_i[5:3])
                : ref_resp(req_a_i[31:0], req_b_i[31:0], req_funct3_i[2:0]);
          exp_q.push_back({g, r});
          last_g = g;
          age = 0;
        end
      end else if (age == 0) begin
        age = 1;
      end else if (rsp_ready_i) begin
        age = -1;
        if (m_count < CNT_MAX) m_count++;
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f3);
    req_valid_i[id]        = v;
    req_a_i[id*32 +: 32]   = a;
    req_b_i[id*32 +: 32]   = b;
    req_funct3_i[id*3 +: 3] = f3;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Present one request and hold it until the DUT takes it.
  task automatic txn(input int id, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f3);
    bit got = 0;
    set_req(id, 1'b1, a, b, f3);
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = req_ready_o[id];
    end
    if (!got) chk("accept_timeout", 0, 1);
    step();
    req_valid_i[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    for (int t = 0; t < 30 && obs_q.size() <= n0; t++) @(posedge clk);
    #1;
    if (obs_q.size() <= n0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_rsp_valid();
    for (int t = 0; t < 10 && !rsp_valid_o; t++) @(negedge clk);
    if (!rsp_valid_o) chk("rsp_valid_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int          n;
    logic [2:0]  e;
    logic [2:0]  f3s[3];
    logic        exp_t[3];
    f3s   = '{3'b100, 3'b110, 3'b111};
    exp_t = '{1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    req_valid_i = '0;
    req_a_i = '0;
    req_b_i = '0;
    req_funct3_i = '0;
    rsp_ready_i = 1'b1;
    step();
    @(negedge clk);
    chk("reset_ready", req_ready_o, 2'b00);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_rsp_id", rsp_id_o, 0);
    chk("reset_taken", rsp_taken_o, 0);
    chk("reset_err", rsp_err_o, 0);
    chk("reset_count", cmp_count_o, 0);
    step();
    rst = 1'b0;
    step();

    // Single BEQ from requester 0: response two cycles after accept.
    set_req(0, 1'b1, 32'd5, 32'd5, 3'b000);
    @(negedge clk);
    chk("t1_ready", req_ready_o, 2'b01);
    step();
    req_valid_i[0] = 1'b0;
    @(negedge clk);
    chk("t1_lat1_valid", rsp_valid_o, 0);
    @(negedge clk);
    chk("t1_lat2_valid", rsp_valid_o, 1);
    chk("t1_id", rsp_id_o, 0);
    chk("t1_taken", rsp_taken_o, 1);
    chk("t1_err", rsp_err_o, 0);
    @(negedge clk);
    chk("t1_count", cmp_count_o, 1);
    step();

    // Both requesters always valid: grants alternate starting from 0.
    pulse_reset();
    n = obs_q.size();
    set_req(0, 1'b1, 32'd1, 32'd2, 3'b100);
    set_req(1, 1'b1, 32'd3, 32'd3, 3'b001);
    for (int t = 0; t < 40 && obs_q.size() < n + 4; t++) step();
    req_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      e = (obs_q.size() > n + i) ? obs_q[n + i] : 3'b111;
      chk($sformatf("rr_id%0d", i), e[2], i % 2);
    end
    repeat (5) step();

    // Signed vs unsigned ordering of 0xFFFFFFFF against 1.
    for (int i = 0; i < 3; i++) begin
      n = obs_q.size();
      txn(1, 32'hFFFF_FFFF, 32'd1, f3s[i]);
      wait_rsp(n);
      e = (obs_q.size() > n) ? obs_q[n] : 3'b000;
      chk($sformatf("edge_taken_f3_%0b", f3s[i]), e[1], exp_t[i]);
      chk($sformatf("edge_err_f3_%0b", f3s[i]), e[0], 0);
    end

    // Illegal funct3 with response back-pressure: fields hold, nothing accepted.
    rsp_ready_i = 1'b0;
    txn(0, 32'd7, 32'd9, 3'b010);
    wait_rsp_valid();
    #1;
    set_req(0, 1'b1, 32'd1, 32'd1, 3'b000);
    set_req(1, 1'b1, 32'd1, 32'd1, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_id", rsp_id_o, 0);
      chk("hold_taken", rsp_taken_o, 0);
      chk("hold_err", rsp_err_o, 1);
      chk("hold_ready", req_ready_o, 2'b00);
    end
    step();
    rsp_ready_i = 1'b1;
    step();
    step();
    req_valid_i = '0;
    repeat (5) step();

    // Reset while a response is pending drops it and restores round-robin.
    rsp_ready_i = 1'b0;
    txn(1, 32'd3, 32'd3, 3'b000);
    wait_rsp_valid();
    step();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_count", cmp_count_o, 0);
    step();
    rst = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid_o, 0);
    end
    step();
    set_req(0, 1'b1, 32'd2, 32'd4, 3'b110);
    set_req(1, 1'b1, 32'd2, 32'd4, 3'b110);
    @(negedge clk);
    chk("rst_first_grant", req_ready_o, 2'b01);
    step();
    req_valid_i = '0;
    repeat (5) step();

    // Counter saturation across 17 handshakes.
    pulse_reset();
    for (int k = 1; k <= 17; k++) begin
      n = obs_q.size();
      txn($urandom_range(0, 1), rnd_op(), rnd_op(), 3'($urandom_range(0, 7)));
      wait_rsp(n);
      if (k >= 14) chk($sformatf("sat_count_k%0d", k), cmp_count_o, (k < CNT_MAX) ? k : CNT_MAX);
    end

    // Random traffic with random back-pressure; the model checks every cycle.
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      for (int id = 0; id < 2; id++) begin
        set_req(id, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 3'($urandom_range(0, 7)));
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_cmp_arbiter.md
BRANCH_CMP_ARBITER -- requirements
Module: branch_cmp_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter CNT_W, default 16, width of the completed-compare counter.
REQ-003 Clocking SHALL be exactly this: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid_i  input  2  per-requester request valid; bit i is requester i.
REQ-007 req_ready_o  output  2  per-requester accept; a request transfers on valid&ready.
REQ-008 req_a_i  input  2xWIDTH  rs1 operand per requester.
REQ-009 req_b_i  input  2xWIDTH  rs2 operand per requester.
REQ-010 req_funct3_i  input  2x3  branch funct3 per requester.
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  response consumer accept.
REQ-013 rsp_id_o  output  1  index of the requester the response belongs to.
REQ-014 rsp_taken_o  output  1  branch condition result.
REQ-015 rsp_err_o  output  1  funct3 was not a legal branch encoding.
REQ-016 cmp_count_o  output  CNT_W  number of responses handed off since reset.

Function
REQ-017 FSM states SHALL be IDLE, EVAL, RESP; reset state IDLE.
REQ-018 In IDLE, req_ready_o SHALL be one-hot on the granted requester if any req_valid_i is set, else zero; ready SHALL be zero in EVAL and RESP.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-grant pointer resets to 1 so requester 0 wins the first contest.
REQ-020 On accept, operands, funct3 and id SHALL be registered and FSM SHALL go IDLE->EVAL; last-grant pointer updates on accept only.
REQ-021 In EVAL the comparator SHALL evaluate the registered operands; unsigned compare for funct3 110/111, signed otherwise; results registered; FSM SHALL go EVAL->RESP unconditionally.
REQ-022 taken: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu; funct3 010/011 SHALL give taken=0, err=1; err=0 for all legal codes.
REQ-023 In RESP, rsp_valid_o SHALL be 1 and rsp_id/taken/err SHALL remain stable until rsp_ready_i; on handshake FSM SHALL go to IDLE.
REQ-024 Accept-to-rsp_valid latency SHALL be exactly 2 cycles; back-to-back throughput SHALL be one compare per 3 cycles with rsp_ready_i held high.
REQ-025 rsp_valid_o SHALL NOT depend combinationally on rsp_ready_i; req_ready_o SHALL NOT depend on rsp_ready_i.
REQ-026 cmp_count_o SHALL increment on each response handshake and saturate at all-ones.
REQ-027 Deasserting req_valid_i after acceptance SHALL have no effect on the in-flight operation.

Reset
REQ-028 On rst: state IDLE, last-grant 1, all operand/result registers 0, cmp_count 0.
REQ-029 Reset outputs: req_ready_o 0 (while no valid), rsp_valid_o 0, rsp_id_o 0, rsp_taken_o 0, rsp_err_o 0, cmp_count_o 0.
REQ-030 Reset asserted in EVAL or RESP SHALL discard the in-flight operation; no response emitted after release.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, the funct3 branch encodings and a localparam for requester count (2).
REQ-032 The comparator SHALL be a sub-module branch_cmp (a, b, unsigned-select in; eq, lt out), purely combinational, instantiated once.

Verification
REQ-033 Req0 a=5,b=5,funct3=000, rsp_ready=1 -> rsp_valid 2 cycles after accept, id=0, taken=1, err=0, count=1.
REQ-034 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; four responses ids 0,1,0,1.
REQ-035 a=0xFFFFFFFF,b=1: funct3=100 -> taken=1; funct3=110 -> taken=0; funct3=111 -> taken=1.
REQ-036 funct3=010 -> taken=0, err=1; rsp_ready held 0 for 5 cycles -> rsp fields stable, no new accept.
REQ-037 rst pulsed while in RESP -> rsp_valid 0 immediately, count 0, next contest won by requester 0.
REQ-038 Force count to all-ones via 2^CNT_W handshakes (CNT_W=4 build) -> count stays 15 after 17th.
